bp_fe_queue_buffer: RTL

BP_FE_QUEUE_BUFFER -- requirements
Module: bp_fe_queue_buffer

---
 rtl/bp_fe_queue_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/bp_fe_queue_buffer.sv
// bp_fe_queue_buffer
// Replayable buffer between the front end and the checker. Entries live
// between the commit pointer and the write pointer; the read pointer runs
// ahead of commit speculatively and can be rolled back to it.
//
// Parameters:
//   els_p    entry count (power of two, >= 2)
//   width_p  entry width in bits
// Ports:
//   clk_i            clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   enq_data_i       entry from the front end
//   enq_v_i          enq_data_i valid
//   enq_ready_o      buffer can accept an entry
//   fe_queue_o       entry at the read pointer
//   fe_queue_v_o     fe_queue_o valid
//   fe_queue_yumi_i  checker consumes fe_queue_o
//   fe_queue_clr_i   discard all unread entries
//   fe_queue_roll_i  replay from the oldest uncommitted entry
//   fe_queue_deq_i   commit all read entries
// Configuration:
//   BP_FE_QUEUE_BUFFER_BYPASS_EN  when defined, an entry arriving at an empty
//   read side is presented on fe_queue_o in the same cycle.

module bp_fe_queue_buffer #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] enq_data_i,
  input  logic               enq_v_i,
  output logic               enq_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_clr_i,
  input  logic               fe_queue_roll_i,
  input  logic               fe_queue_deq_i
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_w_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [ptr_w_lp-1:0] occupancy;
  logic [width_p-1:0]  mem [els_p];
  logic                rd_empty;
  logic                enq_fire;
  logic                yumi_fire;

  // Occupancy counts committed-to-written entries; the wrap bit makes a
  // full buffer (difference == els_p) distinct from an empty one.
  assign occupancy   = wptr_r - cptr_r;
  assign enq_ready_o = (occupancy != ptr_w_lp'(els_p));
  assign rd_empty    = (rptr_r == wptr_r);

`ifdef BP_FE_QUEUE_BUFFER_BYPASS_EN
  assign fe_queue_v_o = rd_empty ? (enq_v_i & enq_ready_o) : 1'b1;
  assign fe_queue_o   = rd_empty ? enq_data_i : mem[rptr_r[lg_els_lp-1:0]];
`else
  assign fe_queue_v_o = ~rd_empty;
  assign fe_queue_o   = mem[rptr_r[lg_els_lp-1:0]];
`endif

  assign enq_fire  = enq_v_i & enq_ready_o & ~fe_queue_clr_i;
  assign yumi_fire = fe_queue_yumi_i & fe_queue_v_o & ~fe_queue_roll_i & ~fe_queue_clr_i;

  // Commit is applied first; roll and clr+roll then target the new cptr.
  always_comb begin
    cptr_n = fe_queue_deq_i ? rptr_r : cptr_r;
    rptr_n = rptr_r;
    wptr_n = wptr_r;

    if (fe_queue_roll_i) begin
      rptr_n = cptr_n;
    end else if (yumi_fire) begin
      rptr_n = rptr_r + ptr_w_lp'(1);
    end

    if (fe_queue_clr_i && fe_queue_roll_i) begin
      wptr_n = cptr_n;
    end else if (fe_queue_clr_i) begin
      // Entries already read stay around so a later roll can replay them.
      wptr_n = rptr_r;
    end else if (enq_fire) begin
      wptr_n = wptr_r + ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      mem[wptr_r[lg_els_lp-1:0]] <= enq_data_i;
    end
  end

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fe_queue_yumi_i && !fe_queue_v_o))
    else $error("fe_queue_yumi_i asserted while fe_queue_v_o is low");

endmodule
